// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR access controller:
//   csr_op_e    - operation encoding presented to the CSR file
//   csr_state_e - access controller FSM states
//   F3_*        - CSR instruction funct3 values and funct3[1:0] kinds
//   CSR_RO_BITS - addr[11:10] pattern marking a read-only CSR
// -----------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } csr_state_e;

    // Full funct3 values of the Zicsr instructions
    localparam logic [2:0] F3_RSVD_REG = 3'b000;
    localparam logic [2:0] F3_CSRRW    = 3'b001;
    localparam logic [2:0] F3_CSRRS    = 3'b010;
    localparam logic [2:0] F3_CSRRC    = 3'b011;
    localparam logic [2:0] F3_RSVD_IMM = 3'b100;
    localparam logic [2:0] F3_CSRRWI   = 3'b101;
    localparam logic [2:0] F3_CSRRSI   = 3'b110;
    localparam logic [2:0] F3_CSRRCI   = 3'b111;

    // funct3[1:0] selects the operation kind, funct3[2] the operand form
    localparam logic [1:0] F3_KIND_NONE  = 2'b00;
    localparam logic [1:0] F3_KIND_WRITE = 2'b01;
    localparam logic [1:0] F3_KIND_SET   = 2'b10;
    localparam logic [1:0] F3_KIND_CLEAR = 2'b11;

    localparam logic [1:0] CSR_RO_BITS = 2'b11;

endpackage

// File: rtl/csr_req_decode.sv
// -----------------------------------------------------------------------------
// csr_req_decode
// Purely combinational decode of a CSR instruction into the CSR file
// operation, its write operand and the illegal-instruction flag.
// Ports:
//   funct3     in  3   CSR instruction funct3
//   rs1_data   in  32  register-form operand
//   zimm       in  5   immediate-form operand
//   rs1_is_x0  in  1   register form names x0
//   addr_hi    in  4   CSR address bits [11:8] (access class + min privilege)
//   priv       in  2   current privilege level
//   op         out 2   operation for the CSR file
//   operand    out 32  write operand
//   illegal    out 1   instruction must trap
// -----------------------------------------------------------------------------
module csr_req_decode
    import csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        rs1_is_x0,
    input  logic [3:0]  addr_hi,
    input  logic [1:0]  priv,
    output csr_op_e     op,
    output logic [31:0] operand,
    output logic        illegal
);

    logic imm_form;
    logic src_zero;
    logic writes;
    logic priv_fault;
    logic ro_fault;

    always_comb begin
        imm_form = funct3[2];
        operand  = imm_form ? {27'b0, zimm} : rs1_data;
        // A zero source makes SET/CLEAR a pure read; CSRRW still writes.
        src_zero = imm_form ? (zimm == '0) : rs1_is_x0;

        case (funct3[1:0])
            F3_KIND_WRITE: op = CSR_OP_WRITE;
            F3_KIND_SET:   op = src_zero ? CSR_OP_READ : CSR_OP_SET;
            F3_KIND_CLEAR: op = src_zero ? CSR_OP_READ : CSR_OP_CLEAR;
            default:       op = CSR_OP_READ;
        endcase

        writes     = (op != CSR_OP_READ);
        priv_fault = (priv < addr_hi[1:0]);
        ro_fault   = writes && (addr_hi[3:2] == CSR_RO_BITS);
        illegal    = (funct3[1:0] == F3_KIND_NONE) || priv_fault || ro_fault;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
// Sequences one CSR instruction at a time between the pipeline and the CSR
// file: accept (IDLE) -> one-cycle CSR file access (ACCESS) -> hold the
// response until consumed (RESP). Illegal requests skip ACCESS entirely.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_funct3, req_addr    instruction funct3 and target CSR address
//   req_rs1_data, req_zimm  register / immediate operands
//   req_rs1_is_x0           rs1 field is x0
//   req_priv                current privilege level
//   flush                   kill of the in-flight CSR instruction
//   csr_op, csr_addr,       CSR file command (non-READ only in ACCESS)
//   csr_wdata
//   csr_rdata               CSR file old value, same-cycle
//   resp_valid/resp_ready   response handshake
//   resp_rdata              old CSR value (0 when illegal)
//   resp_illegal            illegal-instruction flag
// -----------------------------------------------------------------------------
module csr_access_ctrl
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_zimm,
    input  logic        req_rs1_is_x0,
    input  logic [1:0]  req_priv,
    input  logic        flush,
    output logic [1:0]  csr_op,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal
);

    csr_state_e  state;
    csr_op_e     op_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;

    csr_op_e     dec_op;
    logic [31:0] dec_operand;
    logic        dec_illegal;
    logic        accept;

    csr_req_decode u_decode (
        .funct3    (req_funct3),
        .rs1_data  (req_rs1_data),
        .zimm      (req_zimm),
        .rs1_is_x0 (req_rs1_is_x0),
        .addr_hi   (req_addr[11:8]),
        .priv      (req_priv),
        .op        (dec_op),
        .operand   (dec_operand),
        .illegal   (dec_illegal)
    );

    assign accept = req_valid && req_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_illegal <= 1'b0;
            resp_rdata   <= '0;
            op_q         <= CSR_OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (dec_illegal) begin
                            // Trap straight to the response; CSR file untouched.
                            state        <= ST_RESP;
                            resp_valid   <= 1'b1;
                            resp_illegal <= 1'b1;
                            resp_rdata   <= '0;
                        end else begin
                            state        <= ST_ACCESS;
                            resp_illegal <= 1'b0;
                            op_q         <= dec_op;
                            addr_q       <= req_addr;
                            wdata_q      <= dec_operand;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= csr_rdata;
                    end
                end

                ST_RESP: begin
                    // resp_ready and flush together is one completion.
                    if (resp_ready || flush) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // The CSR command is decoded from the registered state so that a flush
    // arriving during ACCESS can still suppress the write in that same cycle.
    always_comb begin
        csr_op    = CSR_OP_READ;
        csr_wdata = '0;
        csr_addr  = addr_q;
        if (state == ST_ACCESS) begin
            csr_wdata = wdata_q;
            if (!flush) begin
                csr_op = op_q;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic        req_rs1_is_x0;
    logic [1:0]  req_priv;
    logic        flush;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [11:0] last_addr;

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_rs1_data  (req_rs1_data),
        .req_zimm      (req_zimm),
        .req_rs1_is_x0 (req_rs1_is_x0),
        .req_priv      (req_priv),
        .flush         (flush),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_illegal  (resp_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          illegal;
        logic [1:0]  op;
        logic [31:0] wdata;
    } exp_t;

    // Reference behaviour from the instruction rules: kind = funct3 mod 4,
    // immediate form when funct3 >= 4.
    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [31:0] rs1, input logic [4:0] zimm,
                                   input logic x0, input logic [1:0] priv);
        exp_t        e;
        int          kind;
        bit          imm;
        bit          no_source;
        bit          writes;
        int          min_priv;
        bit          read_only;
        kind      = int'(f3) % 4;
        imm       = (int'(f3) >= 4);
        no_source = imm ? (int'(zimm) == 0) : (x0 == 1'b1);
        e.wdata   = imm ? 32'(zimm) : rs1;
        case (kind)
            1:       begin e.op = 2'd1; writes = 1; end
            2:       begin e.op = no_source ? 2'd0 : 2'd2; writes = !no_source; end
            3:       begin e.op = no_source ? 2'd0 : 2'd3; writes = !no_source; end
            default: begin e.op = 2'd0; writes = 0; end
        endcase
        min_priv  = int'(addr) / 256 % 4;
        read_only = (int'(addr) / 1024 == 3);
        e.illegal = (kind == 0) || (int'(priv) < min_priv) || (writes && read_only);
        return e;
    endfunction

    // Called at #1 after a rising edge with the DUT in IDLE.
    // flush_at: 0 none, 1 during ACCESS, 2 during RESP (with resp_ready=rdy_w_flush)
    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] rs1, input logic [4:0] zimm,
                           input logic x0, input logic [1:0] priv,
                           input int flush_at, input int hold,
                           input bit rdy_w_flush, input logic [31:0] rdata_val);
        exp_t        e;
        logic [31:0] exp_rdata;
        logic        exp_ill;
        e = model(f3, addr, rs1, zimm, x0, priv);

        check("idle_req_ready", req_ready, 1);
        req_valid     = 1'b1;
        req_funct3    = f3;
        req_addr      = addr;
        req_rs1_data  = rs1;
        req_zimm      = zimm;
        req_rs1_is_x0 = x0;
        req_priv      = priv;
        csr_rdata     = rdata_val;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_addr      = 12'($urandom);
        check("busy_req_ready", req_ready, 0);

        if (!e.illegal) begin
            last_addr = addr;
            check("acc_op", csr_op, e.op);
            check("acc_addr", csr_addr, addr);
            check("acc_wdata", csr_wdata, e.wdata);
            check("acc_resp_valid", resp_valid, 0);
            if (flush_at == 1) begin
                flush = 1'b1;
                #1;
                check("acc_flush_op", csr_op, 2'd0);
            end
            @(posedge clk); #1;
            flush = 1'b0;
            if (flush_at == 1) begin
                check("flushed_resp_valid", resp_valid, 0);
                check("flushed_req_ready", req_ready, 1);
                check("flushed_op", csr_op, 2'd0);
                return;
            end
            exp_rdata = rdata_val;
            exp_ill   = 1'b0;
        end else begin
            check("ill_op", csr_op, 2'd0);
            check("ill_addr", csr_addr, last_addr);
            exp_rdata = '0;
            exp_ill   = 1'b1;
        end

        csr_rdata = $urandom;
        check("resp_valid", resp_valid, 1);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_illegal", resp_illegal, exp_ill);
        check("resp_op", csr_op, 2'd0);
        check("resp_wdata", csr_wdata, 0);
        check("resp_addr", csr_addr, last_addr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_illegal", resp_illegal, exp_ill);
            check("hold_req_ready", req_ready, 0);
        end
        if (flush_at == 2) begin
            flush      = 1'b1;
            resp_ready = rdy_w_flush;
        end else begin
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        check("done_resp_valid", resp_valid, 0);
        check("done_req_ready", req_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_illegal"}, resp_illegal, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_csr_op"}, csr_op, 2'd0);
        check({tag, "_csr_addr"}, csr_addr, 0);
        check({tag, "_csr_wdata"}, csr_wdata, 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        x0;
        int          fm;

        reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
        req_rs1_data = '0; req_zimm = '0; req_rs1_is_x0 = 1'b0; req_priv = 2'd3;
        flush = 1'b0; csr_rdata = '0; resp_ready = 1'b0;
        last_addr = '0;
        #1;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // CSRRW 0x340, then CSRRS x0 0x300, CSRRCI zimm=5
        run_txn(3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0, 2'd3, 0, 0, 0, 32'h12);
        run_txn(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 2'd3, 0, 1, 0, 32'hCAFE0001);
        run_txn(3'b111, 12'h340, 32'h0, 5'd5, 1'b0, 2'd3, 0, 0, 0, 32'h0000FFFF);
        // Read-only address: write illegal, read-only access legal
        run_txn(3'b001, 12'hC00, 32'h1, 5'd0, 1'b0, 2'd3, 0, 0, 0, 32'h77);
        run_txn(3'b010, 12'hC00, 32'h0, 5'd0, 1'b1, 2'd0, 0, 0, 0, 32'h99);
        // Privilege too low; reserved funct3
        run_txn(3'b010, 12'h300, 32'h4, 5'd0, 1'b0, 2'd0, 0, 0, 0, 32'h55);
        run_txn(3'b100, 12'h000, 32'h4, 5'd3, 1'b0, 2'd3, 0, 0, 0, 32'h55);
        // Flush in ACCESS; response held 3 cycles; flush in RESP with and without ready
        run_txn(3'b001, 12'h341, 32'h1234, 5'd0, 1'b0, 2'd3, 1, 0, 0, 32'h66);
        run_txn(3'b011, 12'h342, 32'hF0F0, 5'd0, 1'b0, 2'd3, 0, 3, 0, 32'hABCD);
        run_txn(3'b110, 12'h343, 32'h0, 5'd9, 1'b0, 2'd3, 2, 1, 1, 32'h10);
        run_txn(3'b101, 12'h344, 32'h0, 5'd0, 1'b0, 2'd3, 2, 0, 0, 32'h11);

        // flush in IDLE blocks acceptance
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h345; req_priv = 2'd3;
        flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_ready", req_ready, 1);
        check("idle_flush_valid", resp_valid, 0);
        check("idle_flush_addr", csr_addr, last_addr);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       addr = 12'($urandom);
                1:       addr = {2'b11, 10'($urandom)};
                2:       addr = 12'h300;
                default: addr = 12'h340;
            endcase
            x0   = ($urandom_range(0, 3) == 0);
            rs1  = x0 ? 32'h0 : $urandom;
            zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            fm   = $urandom_range(0, 9);
            fm   = (fm == 0) ? 1 : (fm == 1) ? 2 : 0;
            run_txn(f3, addr, rs1, zimm, x0, 2'($urandom), fm,
                    $urandom_range(0, 3), 1'($urandom), $urandom);
        end

        // Leave non-zero response data, then reset in the middle of ACCESS
        run_txn(3'b001, 12'h305, 32'h1, 5'd0, 1'b0, 2'd3, 0, 0, 0, 32'hA5A5A5A5);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h305;
        req_rs1_data = 32'h0BAD0BAD; req_priv = 2'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_op", csr_op, 2'd1);
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        last_addr = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", resp_valid, 0);
            check("post_rst_ready", req_ready, 1);
            check("post_rst_op", csr_op, 2'd0);
        end
        run_txn(3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 2'd3, 0, 0, 0, 32'h3C3C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
